calc_level_shaper: RTL
======================

Name: calc_level_shaper

Overview:
- Parametrised successor to the SWIPT level calculator.
- Produces the transmit power level `l` from the data bit `d`: an overshoot to full scale (or zero) for a programmable time after each data edge, then a boosted or cut hold level derived from `l_def`.
- Adds `d` synchronisation and synchronous edge detection, a runtime overshoot length, an explicit FSM with status, and a configurable full-scale value.
- Sits between the data framing logic and the PWM/duty generator.

Parameters:
- LW, 12, width of `l_def` and `l`.
- L_MAX, 500, full-scale level; every output is ≤ L_MAX.
- CW, 20, overshoot counter width.
- SYNC_STAGES, 2, flip-flop stages on `d` (minimum 1).
- RAMP_STEP, 8, maximum per-cycle change of `l` (used only with CALC_LEVEL_RAMP_EN).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-high.
- startup_data, in, 1, startup data phase.
- data_start, in, 1, data mode enabled.
- data_trans, in, 1, transmit phase.
- data_rec, in, 1, receive phase; suppresses shaping.
- l_def, in, LW, nominal level.
- ovs_cycles, in, CW, overshoot duration in clk cycles; sampled at each edge.
- d, in, 1, data bit; asynchronous to clk.
- l, out, LW, shaped level.
- phase, out, 3, current FSM state encoding.
- ovs_active, out, 1, high while in OVS_HI or OVS_LO.

Behaviour:
- Reset: `l`=0, state IDLE, counter 0, synchroniser flops 0, `ovs_active`=0.
- Synchronisation and edges:
  - `d` passes through SYNC_STAGES flops to give `ds`; `ds_q` is `ds` delayed one cycle.
  - rise = `ds & ~ds_q`; fall = `~ds & ds_q`.
- Activity condition: `act` = data_start & ~data_rec & (data_trans | startup_data).
- Target levels (combinational, internal width LW+2; `l_def` above L_MAX is saturated to L_MAX first):
  - `hi` = first of `l_def`+`l_def`/2, /3, /4, /5, /10 that is strictly below L_MAX; otherwise `l_def`.
  - `lo` = 2·`l_def` − L_MAX when (L_MAX − `l_def`) < `l_def`/5; otherwise `l_def`/3.
  - All divisions truncate.
- States: IDLE, NOMINAL, OVS_HI, HOLD_HI, OVS_LO, HOLD_LO.
- Transitions, evaluated in priority order:
  1. `act`=0 and data_start=1: NOMINAL, `l`=`l_def` (tracks `l_def` every cycle).
  2. `act`=0 and data_start=0: IDLE, `l` holds its value.
  3. `act`=1 and rise: OVS_HI, `l`=L_MAX, counter=`ovs_cycles`−1. If `ovs_cycles`=0, go directly to HOLD_HI with `l`=`hi`.
  4. `act`=1 and fall: OVS_LO, `l`=0, counter=`ovs_cycles`−1. If `ovs_cycles`=0, go directly to HOLD_LO with `l`=`lo`.
  5. OVS_x with counter≠0: decrement the counter and hold the overshoot level.
  6. OVS_x with counter=0: move to HOLD_x on the next cycle, `l`=`hi` or `lo`.
  7. HOLD_x: `l` follows `hi` or `lo` every cycle, so `l_def` changes propagate with one cycle of latency.
  8. Entering `act` from IDLE or NOMINAL with no edge: go to HOLD_HI if `ds`=1, else HOLD_LO. No overshoot.
- Overshoot length: exactly `ovs_cycles` cycles of L_MAX or 0.
- Edge during overshoot or hold: restarts immediately in the opposite overshoot state, and the counter reloads.
- Latency: `l` is registered. `l`=L_MAX appears SYNC_STAGES+2 clk edges after the edge that first samples the new `d`.
- `act` falling mid-overshoot: the overshoot is abandoned, rules 1/2 apply and the counter clears.
- `rst` has priority over everything.

Optional Feature:
- CALC_LEVEL_RAMP_EN defined:
  - The registered level first computes a target as above.
  - `l` moves toward the target by at most RAMP_STEP per cycle, saturating exactly at the target.
  - Overshoot counting starts at the edge, independent of the ramp.
- Undefined: `l` steps to the target in one cycle. No ramp logic is present.

Decomposition:
- Package calc_level_pkg: state enum `calc_level_state_t` and its 3-bit encodings, default L_MAX constant.
- Sub-module calc_level_targets: purely combinational `hi`/`lo` computation from `l_def` and L_MAX. It is instantiated once and unit-testable in isolation.

Test Plan:
- `l_def`=200, `act`=1, `ovs_cycles`=4, `d` rises → `l`=500 for 4 cycles, then 300. `d` falls → `l`=0 for 4 cycles, then 66.
- `l_def`=400 → `hi`=480, `lo`=133. `l_def`=450 → `hi`=495, `lo`=400. `l_def`=600 (saturates to 500) → `hi`=500, `lo`=500.
- `ovs_cycles`=0, `d` rises → `l`=300 directly, `ovs_active` never asserts.
- `d` falls 2 cycles into a 10-cycle OVS_HI → OVS_LO with a full 10 cycles of 0, then `lo`.
- `data_rec` asserted mid-overshoot with data_start=1 → `l`=`l_def` next cycle, phase=NOMINAL. `rst` pulse → `l`=0, phase=IDLE.
- With CALC_LEVEL_RAMP_EN and RAMP_STEP=8: NOMINAL at 200, then `act` with `d`=1 → `l` rises 208, 216, … and stops exactly at 300.

Source files
------------

// File: rtl/calc_level_pkg.sv
// Shared types and defaults for the transmit level shaper.
package calc_level_pkg;

    localparam int unsigned L_MAX_DEF = 500;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_NOMINAL = 3'd1,
        ST_OVS_HI  = 3'd2,
        ST_HOLD_HI = 3'd3,
        ST_OVS_LO  = 3'd4,
        ST_HOLD_LO = 3'd5
    } calc_level_state_t;

    function automatic logic is_ovs(input calc_level_state_t s);
        return (s == ST_OVS_HI) || (s == ST_OVS_LO);
    endfunction

endpackage

// File: rtl/calc_level_shaper_if.sv
// Control, data and level signals between framing logic, shaper and PWM generator.
interface calc_level_shaper_if #(
    parameter int LW = 12,
    parameter int CW = 20
);
    logic          startup_data;
    logic          data_start;
    logic          data_trans;
    logic          data_rec;
    logic [LW-1:0] l_def;
    logic [CW-1:0] ovs_cycles;
    logic          d;
    logic [LW-1:0] l;
    logic [2:0]    phase;
    logic          ovs_active;

    modport master (
        output startup_data, data_start, data_trans, data_rec, l_def, ovs_cycles, d,
        input  l, phase, ovs_active
    );

    modport slave (
        input  startup_data, data_start, data_trans, data_rec, l_def, ovs_cycles, d,
        output l, phase, ovs_active
    );
endinterface

// File: rtl/calc_level_targets.sv
// Combinational boosted (hi) and cut (lo) hold levels derived from the nominal level.
module calc_level_targets
    import calc_level_pkg::*;
#(
    parameter int LW    = 12,
    parameter int L_MAX = L_MAX_DEF
) (
    input  logic [LW-1:0] l_def,
    output logic [LW-1:0] hi,
    output logic [LW-1:0] lo
);
    localparam int IW = LW + 2;
    localparam logic [IW-1:0] LMAX_W = IW'(L_MAX);

    logic [IW-1:0] base_s;
    logic [IW-1:0] c2_s, c3_s, c4_s, c5_s, c10_s;
    logic [IW-1:0] hi_s, lo_s;

    // Saturate the nominal level and form the boost candidates
    always_comb begin
        if (IW'(l_def) > LMAX_W) begin
            base_s = LMAX_W;
        end else begin
            base_s = IW'(l_def);
        end
        c2_s  = base_s + base_s / IW'(2);
        c3_s  = base_s + base_s / IW'(3);
        c4_s  = base_s + base_s / IW'(4);
        c5_s  = base_s + base_s / IW'(5);
        c10_s = base_s + base_s / IW'(10);
    end

    // Pick the largest boost that stays strictly below full scale
    always_comb begin
        if (c2_s < LMAX_W) begin
            hi_s = c2_s;
        end else if (c3_s < LMAX_W) begin
            hi_s = c3_s;
        end else if (c4_s < LMAX_W) begin
            hi_s = c4_s;
        end else if (c5_s < LMAX_W) begin
            hi_s = c5_s;
        end else if (c10_s < LMAX_W) begin
            hi_s = c10_s;
        end else begin
            hi_s = base_s;
        end
    end

    // Near full scale a cut to a third would be too deep, so mirror about L_MAX
    always_comb begin
        if ((LMAX_W - base_s) < (base_s / IW'(5))) begin
            lo_s = (base_s << 1) - LMAX_W;
        end else begin
            lo_s = base_s / IW'(3);
        end
    end

    assign hi = LW'(hi_s);
    assign lo = LW'(lo_s);

endmodule

// File: rtl/calc_level_shaper.sv
// Transmit level shaper: overshoot after each data edge, then boosted/cut hold level.
// Optional macro CALC_LEVEL_RAMP_EN slew-limits the output by RAMP_STEP per cycle.
module calc_level_shaper
    import calc_level_pkg::*;
#(
    parameter int LW          = 12,
    parameter int L_MAX       = L_MAX_DEF,
    parameter int CW          = 20,
    parameter int SYNC_STAGES = 2,
    parameter int RAMP_STEP   = 8
) (
    input  logic               clk,
    input  logic               rst,
    calc_level_shaper_if.slave bus
);
    localparam logic [LW-1:0] LMAX_L = LW'(L_MAX);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ds_s, ds_q_r, rise_r, fall_r;
    logic                   act_s;
    logic [LW-1:0]          hi_s, lo_s, ldef_sat_s;
    logic [LW-1:0]          l_r, tgt_s, l_nxt_s;
    logic [CW-1:0]          cnt_r, cnt_nxt_s;
    logic                   ovs_r;
    calc_level_state_t      state_r, state_nxt_s;

    calc_level_targets #(.LW(LW), .L_MAX(L_MAX)) u_targets (
        .l_def (bus.l_def),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    assign ds_s       = sync_r[SYNC_STAGES-1];
    assign act_s      = bus.data_start & ~bus.data_rec & (bus.data_trans | bus.startup_data);
    assign ldef_sat_s = (bus.l_def > LMAX_L) ? LMAX_L : bus.l_def;

    // Synchroniser for d; edges are registered, so ds_q_r is the level that matches them
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            ds_q_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r[0] <= bus.d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            ds_q_r <= ds_s;
            rise_r <= ds_s & ~ds_q_r;
            fall_r <= ~ds_s & ds_q_r;
        end
    end

    // Next state, overshoot counter and target level
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        tgt_s       = l_r;
        if (!act_s) begin
            cnt_nxt_s = {CW{1'b0}};
            if (bus.data_start) begin
                state_nxt_s = ST_NOMINAL;
                tgt_s       = ldef_sat_s;
            end else begin
                state_nxt_s = ST_IDLE;
                tgt_s       = l_r;
            end
        end else if (rise_r || fall_r) begin
            if (bus.ovs_cycles == {CW{1'b0}}) begin
                state_nxt_s = rise_r ? ST_HOLD_HI : ST_HOLD_LO;
                tgt_s       = rise_r ? hi_s : lo_s;
                cnt_nxt_s   = {CW{1'b0}};
            end else begin
                state_nxt_s = rise_r ? ST_OVS_HI : ST_OVS_LO;
                tgt_s       = rise_r ? LMAX_L : {LW{1'b0}};
                cnt_nxt_s   = bus.ovs_cycles - CW'(1);
            end
        end else begin
            case (state_r)
                ST_OVS_HI, ST_OVS_LO: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_nxt_s = cnt_r - CW'(1);
                        tgt_s     = (state_r == ST_OVS_HI) ? LMAX_L : {LW{1'b0}};
                    end else begin
                        state_nxt_s = (state_r == ST_OVS_HI) ? ST_HOLD_HI : ST_HOLD_LO;
                        tgt_s       = (state_r == ST_OVS_HI) ? hi_s : lo_s;
                    end
                end
                ST_HOLD_HI: tgt_s = hi_s;
                ST_HOLD_LO: tgt_s = lo_s;
                default: begin
                    state_nxt_s = ds_q_r ? ST_HOLD_HI : ST_HOLD_LO;
                    tgt_s       = ds_q_r ? hi_s : lo_s;
                end
            endcase
        end
    end

`ifdef CALC_LEVEL_RAMP_EN
    localparam logic [LW-1:0] STEP_L = LW'(RAMP_STEP);

    // Slew-limit the level toward the target, landing exactly on it
    always_comb begin
        l_nxt_s = tgt_s;
        if (tgt_s > l_r) begin
            if ((tgt_s - l_r) > STEP_L) begin
                l_nxt_s = l_r + STEP_L;
            end else begin
                l_nxt_s = tgt_s;
            end
        end else if ((l_r - tgt_s) > STEP_L) begin
            l_nxt_s = l_r - STEP_L;
        end else begin
            l_nxt_s = tgt_s;
        end
    end
`else
    assign l_nxt_s = tgt_s;
`endif

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            l_r     <= {LW{1'b0}};
            ovs_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            l_r     <= l_nxt_s;
            ovs_r   <= is_ovs(state_nxt_s);
        end
    end

    assign bus.l          = l_r;
    assign bus.phase      = state_r;
    assign bus.ovs_active = ovs_r;

endmodule
